pipe_stage_buffer: RTL and testbench

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

---
 rtl/pipe_stage_buffer.sv | 124 ++++++++++++
 tb/tb_pipe_stage_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buffer
// Purpose  : Valid/ready pipeline stage holding one (plain) or two (skid)
//            entries, with stall freeze, flush and saturating bubble count.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_buffer #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH      = 2,
    parameter bit                NEG_EDGE   = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              stall_in,
    input  logic              flush,
    output logic              stall_out,
    output logic [1:0]        occupancy,
    output logic [15:0]       bubble_cnt
);

    localparam logic [1:0]  c_occ_empty = 2'd0;
    localparam logic [1:0]  c_occ_full2 = 2'd2;
    localparam logic [15:0] c_bub_max   = 16'hFFFF;

    logic              w_clk;
    logic              w_room;
    logic              w_accept;
    logic              w_release;
    logic [1:0]        w_occ_nxt;
    logic [DATA_W-1:0] w_head_nxt;
    logic [DATA_W-1:0] w_skid_nxt;

    logic [1:0]        r_occ;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_skid;
    logic              r_stall;
    logic [15:0]       r_bub;

    // All state shares one edge; falling-edge builds simply invert the clock.
    generate
        if (NEG_EDGE) begin : g_neg_edge
            assign w_clk = ~clk;
        end else begin : g_pos_edge
            assign w_clk = clk;
        end
    endgenerate

    // The skid build must not look at out_ready so the ready path is registered.
    generate
        if (DEPTH == 1) begin : g_plain
            assign w_room = ~out_valid | out_ready;
        end else begin : g_skid
            assign w_room = (r_occ != c_occ_full2);
        end
    endgenerate

    assign in_ready   = ~rst & ~stall_in & ~flush & w_room;
    assign out_valid  = (r_occ != c_occ_empty);
    assign out_data   = out_valid ? r_head : BUBBLE_VAL;
    assign occupancy  = r_occ;
    assign stall_out  = r_stall;
    assign bubble_cnt = r_bub;

    assign w_accept  = in_valid & in_ready;
    assign w_release = out_valid & out_ready & ~stall_in & ~flush;

    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_skid_nxt = r_skid;
        if (flush) begin
            w_occ_nxt  = c_occ_empty;
            w_head_nxt = BUBBLE_VAL;
        end else if (w_accept && !w_release) begin
            if (r_occ == c_occ_empty) begin
                w_head_nxt = in_data;
            end else begin
                w_skid_nxt = in_data;
            end
            w_occ_nxt = r_occ + 2'd1;
        end else if (w_release && !w_accept) begin
            if (r_occ == c_occ_full2) begin
                w_head_nxt = r_skid;
            end
            w_occ_nxt = r_occ - 2'd1;
        end else if (w_release && w_accept) begin
            // Occupancy holds; the older skid entry advances ahead of the new one.
            if (r_occ == c_occ_full2) begin
                w_head_nxt = r_skid;
                w_skid_nxt = in_data;
            end else begin
                w_head_nxt = in_data;
            end
        end
    end

    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            r_occ   <= c_occ_empty;
            r_head  <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
            r_stall <= 1'b0;
            r_bub   <= 16'd0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_head  <= w_head_nxt;
            r_skid  <= w_skid_nxt;
            r_stall <= stall_in;
            if (!out_valid && (r_bub != c_bub_max)) begin
                r_bub <= r_bub + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buffer.sv
`default_nettype none
// Bench for pipe_stage_buffer: table-driven vectors against a queue scoreboard on a
// falling-edge skid build, plus a rising-edge plain build and reset/saturation sequences.
module tb_pipe_stage_buffer;

    localparam logic [31:0] BUB  = 32'hDEAD_BEEF;
    localparam logic [7:0]  PBUB = 8'hEE;

    logic        clk;
    logic        rst;
    logic        in_valid, out_ready, stall_in, flush;
    logic [31:0] in_data;
    logic        in_ready, out_valid, stall_out;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] bubble_cnt;

    logic        p_in_valid, p_out_ready, p_in_ready, p_out_valid, p_stall_out;
    logic [7:0]  p_in_data, p_out_data;
    logic [1:0]  p_occupancy;
    logic [15:0] p_bubble_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cur_vec = -1;
    int exp_bub = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        ordy;
        logic        st;
        logic        fl;
        logic        rdy;
        logic [1:0]  occ;
    } vec_t;

    vec_t tbl[$];

    pipe_stage_buffer #(
        .DATA_W(32), .DEPTH(2), .NEG_EDGE(1'b1), .BUBBLE_VAL(BUB)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .stall_in(stall_in), .flush(flush),
        .stall_out(stall_out), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_buffer #(
        .DATA_W(8), .DEPTH(1), .NEG_EDGE(1'b0), .BUBBLE_VAL(PBUB)
    ) dut_plain (
        .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_data(p_in_data),
        .in_ready(p_in_ready), .out_valid(p_out_valid), .out_data(p_out_data),
        .out_ready(p_out_ready), .stall_in(1'b0), .flush(1'b0),
        .stall_out(p_stall_out), .occupancy(p_occupancy), .bubble_cnt(p_bubble_cnt)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got %h expected %h", nm, cur_vec, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0; stall_in = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        #1;
        rst = 1'b0;
        sb.delete();
        exp_bub = 0;
    endtask

    task automatic cycle(input vec_t t);
        logic rel, acc, pre_empty;
        logic [31:0] exp_head;
        in_valid = t.v; in_data = t.d; out_ready = t.ordy; stall_in = t.st; flush = t.fl;
        #1;
        pre_empty = (sb.size() == 0);
        exp_head  = pre_empty ? BUB : sb[0];
        chk("in_ready", 32'(in_ready), 32'(t.rdy));
        chk("out_valid", 32'(out_valid), 32'(!pre_empty));
        chk("out_data", out_data, exp_head);
        rel = !pre_empty && t.ordy && !t.st && !t.fl;
        acc = t.v && t.rdy;
        @(posedge clk); #1;
        chk("occ_hold_on_rise", 32'(occupancy), 32'(sb.size()));
        @(negedge clk); #1;
        if (t.fl) begin
            sb.delete();
        end else begin
            if (rel) void'(sb.pop_front());
            if (acc) sb.push_back(t.d);
        end
        if (pre_empty && exp_bub < 65535) exp_bub++;
        chk("occupancy", 32'(occupancy), 32'(t.occ));
        chk("stall_out", 32'(stall_out), 32'(t.st));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(exp_bub));
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        p_in_valid = 1'b0; p_in_data = 8'd0; p_out_ready = 1'b0;

        // Reset state while rst is held
        #1;
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, BUB);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_stall_out", 32'(stall_out), 32'd0);
        chk("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);

        // Rising-edge plain stage
        @(negedge clk); #1;
        rst = 1'b0;
        p_in_valid = 1'b1; p_in_data = 8'h11; p_out_ready = 1'b0;
        #1;
        chk("p_in_ready_empty", 32'(p_in_ready), 32'd1);
        @(posedge clk); #1;
        chk("p_occ_after_push", 32'(p_occupancy), 32'd1);
        chk("p_out_data_first", 32'(p_out_data), 32'h11);
        p_in_data = 8'h22;
        #1;
        chk("p_in_ready_full", 32'(p_in_ready), 32'd0);
        p_out_ready = 1'b1;
        #1;
        chk("p_in_ready_passthru", 32'(p_in_ready), 32'd1);
        @(negedge clk); #1;
        chk("p_hold_on_fall", 32'(p_out_data), 32'h11);
        @(posedge clk); #1;
        chk("p_occ_swap", 32'(p_occupancy), 32'd1);
        chk("p_out_data_second", 32'(p_out_data), 32'h22);
        p_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("p_out_valid_drained", 32'(p_out_valid), 32'd0);
        chk("p_out_data_bubble", 32'(p_out_data), 32'(PBUB));
        p_out_ready = 1'b0;

        // Vector table: {v, d, out_ready, stall, flush, exp in_ready, exp occupancy after edge}
        tbl.push_back('{1'b1, 32'd1,    1'b1, 1'b0, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 32'd2,    1'b1, 1'b0, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 32'd3,    1'b1, 1'b0, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 32'hA5,   1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 32'hB6,   1'b0, 1'b0, 1'b0, 1'b1, 2'd2});
        tbl.push_back('{1'b0, 32'd0,    1'b0, 1'b0, 1'b0, 1'b0, 2'd2});
        tbl.push_back('{1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 32'h11,   1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 32'h12,   1'b0, 1'b0, 1'b0, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 32'h99,   1'b1, 1'b1, 1'b0, 1'b0, 2'd2});
        tbl.push_back('{1'b1, 32'h99,   1'b1, 1'b1, 1'b0, 1'b0, 2'd2});
        tbl.push_back('{1'b1, 32'h99,   1'b1, 1'b1, 1'b0, 1'b0, 2'd2});
        tbl.push_back('{1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 32'h41,   1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 32'h42,   1'b1, 1'b1, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{1'b1, 32'h43,   1'b1, 1'b0, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 32'h21,   1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 32'h22,   1'b0, 1'b0, 1'b0, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 32'h77,   1'b1, 1'b1, 1'b1, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 32'h61,   1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 32'h62,   1'b1, 1'b0, 1'b1, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 32'd0,    1'b0, 1'b0, 1'b0, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 32'h31,   1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 32'h32,   1'b0, 1'b0, 1'b0, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 32'h33,   1'b1, 1'b0, 1'b0, 1'b0, 2'd1});
        tbl.push_back('{1'b1, 32'h33,   1'b1, 1'b0, 1'b0, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 32'd0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd0});

        do_reset();
        foreach (tbl[i]) begin
            cur_vec = i;
            cycle(tbl[i]);
        end

        // Asynchronous reset between edges with one entry held
        cur_vec = 100;
        cycle('{1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        chk("arst_out_data", out_data, BUB);
        chk("arst_bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Idle until the bubble counter saturates
        cur_vec = 200;
        repeat (65534) @(negedge clk);
        #1;
        chk("bubble_below_sat", 32'(bubble_cnt), 32'd65534);
        @(negedge clk); #1;
        chk("bubble_at_sat", 32'(bubble_cnt), 32'hFFFF);
        repeat (4465) @(negedge clk);
        #1;
        chk("bubble_held_sat", 32'(bubble_cnt), 32'hFFFF);
        chk("idle_out_data", out_data, BUB);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
